spi_frame_tx: RTL and testbench
===============================

Name: spi_frame_tx

Overview:
- SPI-style master transmitter that drives the `ce`/`sck`/`sdo` link consumed by the FPGA frame receiver.
- Serialises one FRAME_W-bit note/control word, MSB first, under an active-high `ce` window.
- Used as the MCU-side stand-in in simulation and as an on-FPGA loopback source.
- Sits between a frame producer (`load`/`frame`) and the top-level receiver's `ce` and serial inputs.

Parameters:
- FRAME_W, 40, bits per frame.
- CLK_DIV, 4, `clk` cycles per `sck` half-period; legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- nreset  input  1  asynchronous active-low reset.
- load  input  1  start request; sampled only in IDLE.
- frame  input  FRAME_W  word to send; captured on accepted `load`.
- busy  output  1  high from the cycle after accept until the cycle `done` pulses (exclusive).
- done  output  1  one-cycle pulse when `ce` drops.
- ce  output  1  active-high frame enable.
- sck  output  1  serial clock, idle low.
- sdo  output  1  serial data, MSB first.

Behaviour:
- Reset (async, nreset=0): state=IDLE; ce=0, sck=0, sdo=0, busy=0, done=0; shift register, bit counter and divider cleared. Reset asserted mid-frame aborts immediately; no `done` pulse.
- Divider: counter loads CLK_DIV-1 on each state/phase entry, decrements every `clk`; a "tick" occurs when it reaches 0.
- States: IDLE → SETUP → SHIFT_HI → SHIFT_LO → (SHIFT_HI | HOLD) → IDLE.
- IDLE:
  - `load`=1 accepts (cycle 0): shift register ← frame, bit count ← FRAME_W.
  - Next cycle: SETUP, ce=1, busy=1, sdo=frame[FRAME_W-1].
- SETUP: lasts CLK_DIV cycles, sck=0; tick → SHIFT_HI.
- SHIFT_HI: sck=1 for CLK_DIV cycles; receiver samples on this rising edge (mode 0). Tick → SHIFT_LO.
- SHIFT_LO: sck=0 for CLK_DIV cycles. On entry, shift left by one, decrement bit count, and sdo presents the next MSB. On tick:
  - bit count ≠ 0 → SHIFT_HI.
  - otherwise → HOLD.
- HOLD: ce=1, sck=0, sdo=0 for CLK_DIV cycles. Tick → IDLE with ce=0, busy=0, done=1 in that same cycle.
- ce-high duration: exactly (2·FRAME_W+2)·CLK_DIV cycles. Default is 328 cycles.
- Exactly FRAME_W rising `sck` edges per frame. `sdo` changes only while sck=0 and is stable across each rising edge.
- `load` while busy is ignored; `frame` changes while busy have no effect.
- `load` in the same cycle as the `done` pulse is accepted (state is IDLE) → back-to-back frames have ce low for exactly 1 cycle.
- CLK_DIV=1: sck toggles every `clk`; all rules above still hold.
- Counters sized `$clog2(FRAME_W+1)` and `$clog2(CLK_DIV)+1`; no wrap occurs in legal operation.

Optional Feature:
- Macro: SPI_FRAME_TX_PARITY_EN.
- Defined:
  - One extra bit is sent after the LSB: odd parity over `frame`, i.e. ~^frame.
  - FRAME_W+1 rising edges per frame.
  - ce-high duration becomes (2·FRAME_W+4)·CLK_DIV cycles.
  - Parity is computed at accept time.
- Undefined: exactly FRAME_W bits, no parity logic synthesised.

Test Plan:
- Reset values: hold nreset=0, toggle `load` → ce=sck=sdo=busy=done=0 throughout. Release → still IDLE until `load`.
- Single frame, defaults: load frame=40'h42B46D8012 → bench SPI monitor captures 40'h42B46D8012, exactly 40 rising `sck` edges, ce high 328 cycles, one `done` pulse, busy high 328 cycles.
- Busy rejection: during frame 40'h42B46D8012, pulse `load` with 40'hFFFFFFFFFF → captured word is unchanged, and no second frame starts.
- Back-to-back: assert `load` (40'h0000000001) in the `done` cycle of a prior frame → ce low exactly 1 cycle, second capture = 40'h0000000001.
- Reset mid-frame: assert nreset=0 after 17 `sck` rises → outputs idle asynchronously, no `done`. After release, a new load of 40'hA5A5A5A5A5 transmits correctly.
- CLK_DIV=1 and PARITY_EN build: send 40'h42B46D8012 → 41 rising edges, last bit = ~^40'h42B46D8012, ce high 84 cycles.

Source files
------------

// File: rtl/spi_frame_tx.sv
// SPI-style mode-0 master: sends one FRAME_W-bit word MSB first under an active-high ce window.
// Define SPI_FRAME_TX_PARITY_EN to append an odd-parity bit (~^frame) after the LSB.
module spi_frame_tx #(
  parameter int FRAME_W = 40,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               done,
  output logic               ce,
  output logic               sck,
  output logic               sdo
);

`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int NBITS = FRAME_W + 1;
`else
  localparam int NBITS = FRAME_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(NBITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [NBITS-1:0]   sreg, sreg_nxt;
  logic [NBITS-1:0]   load_word;
  logic [CNT_W-1:0]   bits, bits_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic               tick;
  logic               done_nxt;
  logic               ce_nxt, busy_nxt, sck_nxt, sdo_nxt;

`ifdef SPI_FRAME_TX_PARITY_EN
  // Parity rides at the bottom of the shift register so it leaves after the LSB.
  assign load_word = {frame, ~^frame};
`else
  assign load_word = frame;
`endif

  assign tick = (div == '0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      sreg  <= '0;
      bits  <= '0;
      div   <= '0;
      ce    <= 1'b0;
      busy  <= 1'b0;
      sck   <= 1'b0;
      sdo   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      bits  <= bits_nxt;
      div   <= div_nxt;
      ce    <= ce_nxt;
      busy  <= busy_nxt;
      sck   <= sck_nxt;
      sdo   <= sdo_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bits_nxt  = bits;
    div_nxt   = tick ? div : div - DIV_ONE;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SETUP;
          sreg_nxt  = load_word;
          bits_nxt  = CNT_FULL;
          div_nxt   = DIV_RELOAD;
        end
      end
      SETUP: begin
        if (tick) begin
          state_nxt = SHIFT_HI;
          div_nxt   = DIV_RELOAD;
        end
      end
      SHIFT_HI: begin
        // Shift on the falling sck edge so sdo settles during the low phase.
        if (tick) begin
          state_nxt = SHIFT_LO;
          div_nxt   = DIV_RELOAD;
          sreg_nxt  = {sreg[NBITS-2:0], 1'b0};
          bits_nxt  = bits - CNT_ONE;
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          div_nxt   = DIV_RELOAD;
          state_nxt = (bits != '0) ? SHIFT_HI : HOLD;
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they change cleanly with the state itself.
    ce_nxt   = (state_nxt != IDLE);
    busy_nxt = (state_nxt != IDLE);
    sck_nxt  = (state_nxt == SHIFT_HI);
    sdo_nxt  = ((state_nxt == SETUP) || (state_nxt == SHIFT_HI) || (state_nxt == SHIFT_LO))
               && sreg_nxt[NBITS-1];
  end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two instances (CLK_DIV=4 and CLK_DIV=1) observed by a protocol monitor.
// Expected frames come from a bit-level model of the link; honours SPI_FRAME_TX_PARITY_EN.
module tb_spi_frame_tx;
  localparam int FW = 40;
`ifdef SPI_FRAME_TX_PARITY_EN
  localparam int NB = FW + 1;
`else
  localparam int NB = FW;
`endif

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          load = 1'b0;
  logic          sel = 1'b0;
  logic [FW-1:0] frame = '0;
  logic          load0, load1;
  logic          busy0, done0, ce0, sck0, sdo0;
  logic          busy1, done1, ce1, sck1, sdo1;
  logic          m_busy, m_done, m_ce, m_sck, m_sdo;
  logic [9:0]    all_out;

  always #5 clk = ~clk;

  assign load0 = load & ~sel;
  assign load1 = load & sel;

  spi_frame_tx #(.FRAME_W(FW), .CLK_DIV(4)) u_dut0 (
    .clk(clk), .nreset(nreset), .load(load0), .frame(frame),
    .busy(busy0), .done(done0), .ce(ce0), .sck(sck0), .sdo(sdo0)
  );

  spi_frame_tx #(.FRAME_W(FW), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .nreset(nreset), .load(load1), .frame(frame),
    .busy(busy1), .done(done1), .ce(ce1), .sck(sck1), .sdo(sdo1)
  );

  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;
  assign m_ce    = sel ? ce1   : ce0;
  assign m_sck   = sel ? sck1  : sck0;
  assign m_sdo   = sel ? sdo1  : sdo0;
  assign all_out = {ce0, sck0, sdo0, busy0, done0, ce1, sck1, sdo1, busy1, done1};

  typedef struct {
    logic [63:0] word;
    int          edges;
    int          ce_len;
    int          busy_len;
    logic        done_end;
    int          gap;
  } rec_t;

  typedef struct {
    logic          sel;
    logic [FW-1:0] frame;
    logic [63:0]   exp_word;
    int            exp_edges;
    int            exp_ce;
  } vec_t;

  rec_t results[$];
  rec_t cur;
  bit   in_frame = 0;
  int   gap_cnt = 0;
  logic prev_ce = 1'b0, prev_sck = 1'b0, prev_sdo = 1'b0;
  int   done_total = 0, frames_pushed = 0, proto_bad = 0;
  int   checks = 0, errors = 0;

  // Reference: the bit sequence a receiver must see, frame MSB first then optional odd parity.
  function automatic logic [63:0] model_word(input logic [FW-1:0] f);
    logic [63:0] w;
    w = 64'(f);
`ifdef SPI_FRAME_TX_PARITY_EN
    begin
      logic p;
      p = 1'b1;
      for (int i = 0; i < FW; i++) p = p ^ f[i];
      w = {w[62:0], p};
    end
`endif
    return w;
  endfunction

  function automatic int model_ce_len(input logic s);
    return (2 * NB + 2) * (s ? 1 : 4);
  endfunction

  // Link monitor: one sample per clk cycle, on the falling edge.
  initial begin
    cur = '{word: '0, edges: 0, ce_len: 0, busy_len: 0, done_end: 1'b0, gap: 0};
    forever begin
      @(negedge clk);
      if (!nreset) begin
        in_frame = 0;
        gap_cnt  = 0;
        prev_ce  = 1'b0;
        prev_sck = 1'b0;
        prev_sdo = 1'b0;
      end else begin
        if (m_done) done_total++;
        if (m_busy != m_ce) proto_bad++;
        if (!m_ce && (m_sck || m_sdo)) proto_bad++;
        if (m_sck && (m_sdo != prev_sdo)) proto_bad++;
        if (m_ce && !prev_ce) begin
          cur = '{word: '0, edges: 0, ce_len: 0, busy_len: 0, done_end: 1'b0, gap: gap_cnt};
          in_frame = 1;
        end
        if (m_ce) begin
          gap_cnt = 0;
          cur.ce_len++;
          if (m_busy) cur.busy_len++;
          if (m_sck && !prev_sck) begin
            cur.word = {cur.word[62:0], m_sdo};
            cur.edges++;
          end
        end else begin
          gap_cnt++;
          if (prev_ce && in_frame) begin
            cur.done_end = m_done;
            results.push_back(cur);
            frames_pushed++;
            in_frame = 0;
          end
        end
        prev_ce  = m_ce;
        prev_sck = m_sck;
        prev_sdo = m_sdo;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic s, input logic [FW-1:0] f);
    @(posedge clk); #1;
    sel   = s;
    frame = f;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic get_result(output rec_t r, output bit ok);
    ok = 0;
    r  = '{word: '0, edges: 0, ce_len: 0, busy_len: 0, done_end: 1'b0, gap: 0};
    for (int i = 0; i < 2000; i++) begin
      if (results.size() > 0) break;
      @(posedge clk);
    end
    if (results.size() > 0) begin
      r  = results.pop_front();
      ok = 1;
    end else begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no completed frame in 2000 cycles, expected one");
    end
  endtask

  task automatic check_frame(input string tag, input rec_t r, input logic [63:0] exp_word,
                             input int exp_edges, input int exp_ce);
    chk({tag, "_word"},  r.word, exp_word);
    chk({tag, "_edges"}, 64'(r.edges), 64'(exp_edges));
    chk({tag, "_ce"},    64'(r.ce_len), 64'(exp_ce));
    chk({tag, "_busy"},  64'(r.busy_len), 64'(exp_ce));
    chk({tag, "_done"},  64'(r.done_end), 64'd1);
  endtask

  vec_t vecs[6];

  initial begin
    rec_t        r, r2;
    bit          ok, ok2, seen;
    int          snap;
    logic [31:0] ra, rb;
    logic [FW-1:0] rf;
    logic          rs;

    vecs[0] = '{1'b0, 40'h42B46D8012, model_word(40'h42B46D8012), NB, model_ce_len(1'b0)};
    vecs[1] = '{1'b1, 40'h42B46D8012, model_word(40'h42B46D8012), NB, model_ce_len(1'b1)};
    vecs[2] = '{1'b0, 40'h0000000000, model_word(40'h0000000000), NB, model_ce_len(1'b0)};
    vecs[3] = '{1'b0, 40'hFFFFFFFFFF, model_word(40'hFFFFFFFFFF), NB, model_ce_len(1'b0)};
    vecs[4] = '{1'b1, 40'h8000000001, model_word(40'h8000000001), NB, model_ce_len(1'b1)};
    vecs[5] = '{1'b1, 40'h0000000001, model_word(40'h0000000001), NB, model_ce_len(1'b1)};

    // Reset held: load toggling must not wake either instance.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      load  = ~load;
      sel   = (i >= 2);
      frame = 40'hFFFFFFFFFF;
      #2 chk("reset_outputs", 64'(all_out), 64'd0);
    end
    load = 1'b0;
    sel  = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("idle_after_release", 64'(all_out), 64'd0);
    chk("no_frame_without_load", 64'(results.size()), 64'd0);

    // Table of single frames on both instances.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].sel, vecs[v].frame);
      get_result(r, ok);
      if (ok) check_frame($sformatf("vec%0d", v), r, vecs[v].exp_word, vecs[v].exp_edges, vecs[v].exp_ce);
      repeat (3) @(posedge clk);
    end

    // A load while busy must neither alter nor restart the frame.
    send(1'b0, 40'h42B46D8012);
    repeat (60) @(posedge clk);
    #1 chk("busy_mid_frame", 64'(m_busy), 64'd1);
    load  = 1'b1;
    frame = 40'hFFFFFFFFFF;
    @(posedge clk); #1;
    load  = 1'b0;
    get_result(r, ok);
    if (ok) chk("reject_word", r.word, model_word(40'h42B46D8012));
    repeat (400) @(posedge clk);
    chk("reject_no_second_frame", 64'(results.size()), 64'd0);
    #1 chk("reject_ce_low", 64'(m_ce), 64'd0);

    // Back-to-back: load issued in the done cycle.
    send(1'b0, 40'h42B46D8012);
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk); #1;
      if (m_done) seen = 1;
    end
    chk("b2b_done_seen", 64'(seen), 64'd1);
    load  = 1'b1;
    frame = 40'h0000000001;
    @(posedge clk); #1;
    load  = 1'b0;
    get_result(r, ok);
    get_result(r2, ok2);
    if (ok)  chk("b2b_first_word", r.word, model_word(40'h42B46D8012));
    if (ok2) begin
      chk("b2b_second_word", r2.word, model_word(40'h0000000001));
      chk("b2b_ce_gap", 64'(r2.gap), 64'd1);
      chk("b2b_second_edges", 64'(r2.edges), 64'(NB));
    end

    // Asynchronous reset after 17 sck rises aborts without a done pulse.
    repeat (3) @(posedge clk);
    send(1'b0, 40'h42B46D8012);
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      if (in_frame && cur.edges >= 17) seen = 1;
    end
    chk("abort_reached_17", 64'(seen), 64'd1);
    snap = done_total;
    #1 nreset = 1'b0;
    #1 chk("abort_outputs_idle", 64'(all_out), 64'd0);
    repeat (4) @(posedge clk);
    #1 chk("abort_outputs_stay", 64'(all_out), 64'd0);
    nreset = 1'b1;
    repeat (400) @(posedge clk);
    chk("abort_no_done", 64'(done_total), 64'(snap));
    chk("abort_no_frame", 64'(results.size()), 64'd0);
    send(1'b0, 40'hA5A5A5A5A5);
    get_result(r, ok);
    if (ok) check_frame("after_abort", r, model_word(40'hA5A5A5A5A5), NB, model_ce_len(1'b0));

    // Random frames against the model.
    for (int n = 0; n < 8; n++) begin
      ra = $urandom();
      rb = $urandom();
      rf = {ra[7:0], rb};
      rs = ra[8];
      repeat (ra[11:9]) @(posedge clk);
      send(rs, rf);
      get_result(r, ok);
      if (ok) check_frame($sformatf("rand%0d", n), r, model_word(rf), NB, model_ce_len(rs));
    end

    repeat (5) @(posedge clk);
    chk("protocol_violations", 64'(proto_bad), 64'd0);
    chk("done_per_frame", 64'(done_total), 64'(frames_pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
